// File: rtl/demux2_router_pkg.sv
// Shared types and constants for the demux2_router steering block.
package demux2_router_pkg;

  typedef enum logic [1:0] {
    Q_EMPTY = 2'd0,
    Q_ONE   = 2'd1,
    Q_TWO   = 2'd2
  } q_state_e;

  localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/demux2_router_if.sv
// Val/rdy bundle for demux2_router: one input stream and two output streams.
interface demux2_router_if #(
  parameter int unsigned nbits = 4
);

  logic             in_val;
  logic             in_rdy;
  logic [nbits-1:0] in_msg;
  logic             in_sel;
  logic             out0_val;
  logic             out0_rdy;
  logic [nbits-1:0] out0_msg;
  logic             out1_val;
  logic             out1_rdy;
  logic [nbits-1:0] out1_msg;

  // Producer/consumer side of the router
  modport master (
    output in_val, in_msg, in_sel, out0_rdy, out1_rdy,
    input  in_rdy, out0_val, out0_msg, out1_val, out1_msg
  );

  // Router side
  modport slave (
    input  in_val, in_msg, in_sel, out0_rdy, out1_rdy,
    output in_rdy, out0_val, out0_msg, out1_val, out1_msg
  );

endinterface

// File: rtl/demux_queue2.sv
// Two-entry val/rdy FIFO; head register is cleared when empty so deq_msg_o reads zero.
module demux_queue2
  import demux2_router_pkg::*;
#(
  parameter int unsigned nbits = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enq_val_i,
  output logic             enq_rdy_o,
  input  logic [nbits-1:0] enq_msg_i,
  output logic             deq_val_o,
  input  logic             deq_rdy_i,
  output logic [nbits-1:0] deq_msg_o
);

  q_state_e         state_q, state_d;
  logic [nbits-1:0] head_q, head_d;
  logic [nbits-1:0] tail_q, tail_d;
  logic             enq;
  logic             deq;

  // No full bypass: a TWO queue refuses enqueue even while dequeuing
  assign enq_rdy_o = (state_q != Q_TWO);
  assign deq_val_o = (state_q != Q_EMPTY);
  assign deq_msg_o = head_q;
  assign enq       = enq_val_i && enq_rdy_o;
  assign deq       = deq_val_o && deq_rdy_i;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      Q_EMPTY: begin
        if (enq) begin
          state_d = Q_ONE;
          head_d  = enq_msg_i;
        end
      end
      Q_ONE: begin
        if (enq && deq) begin
          head_d = enq_msg_i;
        end else if (enq) begin
          state_d = Q_TWO;
          tail_d  = enq_msg_i;
        end else if (deq) begin
          state_d = Q_EMPTY;
          head_d  = '0;
        end
      end
      Q_TWO: begin
        if (deq) begin
          state_d = Q_ONE;
          head_d  = tail_q;
          tail_d  = '0;
        end
      end
      default: begin
        state_d = Q_EMPTY;
        head_d  = '0;
        tail_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= Q_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: rtl/demux2_router.sv
// Routes one val/rdy stream to two buffered outputs by per-message select bit.
// Optional per-output transfer counters under macro DEMUX2_ROUTER_COUNT_EN.
module demux2_router
  import demux2_router_pkg::*;
#(
  parameter int unsigned nbits = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  demux2_router_if.slave         bus
`ifdef DEMUX2_ROUTER_COUNT_EN
  ,
  output logic [CNT_W-1:0]       out0_count,
  output logic [CNT_W-1:0]       out1_count
`endif
);

  logic q0_enq_rdy;
  logic q1_enq_rdy;

  // Ready tracks only the queue currently selected, so the other side never blocks
  assign bus.in_rdy = bus.in_sel ? q1_enq_rdy : q0_enq_rdy;

  demux_queue2 #(.nbits(nbits)) u_q0 (
    .clk       (clk),
    .rst       (rst),
    .enq_val_i (bus.in_val && !bus.in_sel),
    .enq_rdy_o (q0_enq_rdy),
    .enq_msg_i (bus.in_msg),
    .deq_val_o (bus.out0_val),
    .deq_rdy_i (bus.out0_rdy),
    .deq_msg_o (bus.out0_msg)
  );

  demux_queue2 #(.nbits(nbits)) u_q1 (
    .clk       (clk),
    .rst       (rst),
    .enq_val_i (bus.in_val && bus.in_sel),
    .enq_rdy_o (q1_enq_rdy),
    .enq_msg_i (bus.in_msg),
    .deq_val_o (bus.out1_val),
    .deq_rdy_i (bus.out1_rdy),
    .deq_msg_o (bus.out1_msg)
  );

`ifdef DEMUX2_ROUTER_COUNT_EN
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  // Output transfer counters, wrapping naturally at 2**CNT_W
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (bus.out0_val && bus.out0_rdy) cnt0_q <= cnt0_q + CNT_W'(1);
      if (bus.out1_val && bus.out1_rdy) cnt1_q <= cnt1_q + CNT_W'(1);
    end
  end

  assign out0_count = cnt0_q;
  assign out1_count = cnt1_q;
`endif

endmodule

// File: tb/tb_demux2_router.sv
// Self-checking bench for demux2_router: directed scenarios plus random traffic vs a queue model.
module tb_demux2_router;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  demux2_router_if #(.nbits(4)) bus ();

`ifdef DEMUX2_ROUTER_COUNT_EN
  logic [7:0] c0, c1;
`endif

  demux2_router #(.nbits(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus)
`ifdef DEMUX2_ROUTER_COUNT_EN
    ,
    .out0_count (c0),
    .out1_count (c1)
`endif
  );

  task automatic drive(input logic v, input logic s, input logic [3:0] m,
                       input logic r0, input logic r1);
    bus.in_val   = v;
    bus.in_sel   = s;
    bus.in_msg   = m;
    bus.out0_rdy = r0;
    bus.out1_rdy = r1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    #3;
    tests++; if (bus.out0_val !== 1'b0) begin fails++; $display("FAIL reset_out0_val: got %b expected 0", bus.out0_val); end
    tests++; if (bus.out1_val !== 1'b0) begin fails++; $display("FAIL reset_out1_val: got %b expected 0", bus.out1_val); end
    tests++; if (bus.out0_msg !== 4'h0) begin fails++; $display("FAIL reset_out0_msg: got %h expected 0", bus.out0_msg); end
    tests++; if (bus.out1_msg !== 4'h0) begin fails++; $display("FAIL reset_out1_msg: got %h expected 0", bus.out1_msg); end
    tests++; if (bus.in_rdy !== 1'b1) begin fails++; $display("FAIL reset_in_rdy_sel0: got %b expected 1", bus.in_rdy); end
    bus.in_sel = 1'b1;
    #1;
    tests++; if (bus.in_rdy !== 1'b1) begin fails++; $display("FAIL reset_in_rdy_sel1: got %b expected 1", bus.in_rdy); end
`ifdef DEMUX2_ROUTER_COUNT_EN
    tests++; if (c0 !== 8'd0 || c1 !== 8'd0) begin fails++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", c0, c1); end
`endif
    tick();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    drive(1'b1, 1'b0, 4'h5, 1'b1, 1'b1);
    #1;
    tests++; if (bus.in_rdy !== 1'b1) begin fails++; $display("FAIL basic_in_rdy: got %b expected 1", bus.in_rdy); end
    tick();
    drive(1'b1, 1'b1, 4'hA, 1'b1, 1'b1);
    #1;
    tests++; if (bus.out0_val !== 1'b1 || bus.out0_msg !== 4'h5) begin fails++; $display("FAIL basic_out0: got val=%b msg=%h expected val=1 msg=5", bus.out0_val, bus.out0_msg); end
    tests++; if (bus.out1_val !== 1'b0) begin fails++; $display("FAIL basic_out1_early: got %b expected 0", bus.out1_val); end
    tick();
    drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    #1;
    tests++; if (bus.out0_val !== 1'b0 || bus.out0_msg !== 4'h0) begin fails++; $display("FAIL basic_out0_drain: got val=%b msg=%h expected val=0 msg=0", bus.out0_val, bus.out0_msg); end
    tests++; if (bus.out1_val !== 1'b1 || bus.out1_msg !== 4'hA) begin fails++; $display("FAIL basic_out1: got val=%b msg=%h expected val=1 msg=a", bus.out1_val, bus.out1_msg); end
    tick();
    tests++; if (bus.out1_val !== 1'b0 || bus.out1_msg !== 4'h0) begin fails++; $display("FAIL basic_out1_drain: got val=%b msg=%h expected val=0 msg=0", bus.out1_val, bus.out1_msg); end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 1'b0, 4'h1, 1'b0, 1'b1);
    tick();
    drive(1'b1, 1'b0, 4'h2, 1'b0, 1'b1);
    #1;
    tests++; if (bus.in_rdy !== 1'b1) begin fails++; $display("FAIL bp_rdy_one: got %b expected 1", bus.in_rdy); end
    tick();
    drive(1'b1, 1'b0, 4'h3, 1'b0, 1'b1);
    #1;
    tests++; if (bus.in_rdy !== 1'b0) begin fails++; $display("FAIL bp_rdy_full: got %b expected 0", bus.in_rdy); end
    tick();
    drive(1'b1, 1'b0, 4'h3, 1'b1, 1'b1);
    #1;
    tests++; if (bus.in_rdy !== 1'b0) begin fails++; $display("FAIL bp_no_bypass: got %b expected 0", bus.in_rdy); end
    tests++; if (bus.out0_msg !== 4'h1) begin fails++; $display("FAIL bp_drain1: got %h expected 1", bus.out0_msg); end
    tick();
    #1;
    tests++; if (bus.in_rdy !== 1'b1) begin fails++; $display("FAIL bp_rdy_back: got %b expected 1", bus.in_rdy); end
    tests++; if (bus.out0_msg !== 4'h2) begin fails++; $display("FAIL bp_drain2: got %h expected 2", bus.out0_msg); end
    tick();
    drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    #1;
    tests++; if (bus.out0_val !== 1'b1 || bus.out0_msg !== 4'h3) begin fails++; $display("FAIL bp_drain3: got val=%b msg=%h expected val=1 msg=3", bus.out0_val, bus.out0_msg); end
    tick();
    tests++; if (bus.out0_val !== 1'b0 || bus.in_rdy !== 1'b1) begin fails++; $display("FAIL bp_empty: got val=%b rdy=%b expected val=0 rdy=1", bus.out0_val, bus.in_rdy); end
  endtask

  task automatic test_hol();
    drive(1'b1, 1'b0, 4'h1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 4'h2, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 4'h7, 1'b0, 1'b0);
    #1;
    tests++; if (bus.in_rdy !== 1'b1) begin fails++; $display("FAIL hol_rdy_sel1: got %b expected 1", bus.in_rdy); end
    tick();
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    #1;
    tests++; if (bus.out1_val !== 1'b1 || bus.out1_msg !== 4'h7) begin fails++; $display("FAIL hol_out1: got val=%b msg=%h expected val=1 msg=7", bus.out1_val, bus.out1_msg); end
    tests++; if (bus.out0_msg !== 4'h1 || bus.in_rdy !== 1'b0) begin fails++; $display("FAIL hol_out0_held: got msg=%h rdy=%b expected msg=1 rdy=0", bus.out0_msg, bus.in_rdy); end
    drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    tick();
    tick();
    tests++; if (bus.out0_val !== 1'b0 || bus.out1_val !== 1'b0) begin fails++; $display("FAIL hol_drained: got %b/%b expected 0/0", bus.out0_val, bus.out1_val); end
  endtask

  task automatic test_ones_steady();
    drive(1'b1, 1'b0, 4'h0, 1'b1, 1'b1);
    tick();
    for (int i = 1; i < 8; i++) begin
      drive(1'b1, 1'b0, 4'(i), 1'b1, 1'b1);
      #1;
      tests++;
      if (bus.out0_val !== 1'b1 || bus.out0_msg !== 4'(i - 1) || bus.in_rdy !== 1'b1) begin
        fails++;
        $display("FAIL ones_step%0d: got val=%b msg=%h rdy=%b expected val=1 msg=%h rdy=1",
                 i, bus.out0_val, bus.out0_msg, bus.in_rdy, 4'(i - 1));
      end
      tick();
    end
    drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    #1;
    tests++; if (bus.out0_msg !== 4'h7) begin fails++; $display("FAIL ones_last: got %h expected 7", bus.out0_msg); end
    tick();
    tests++; if (bus.out0_val !== 1'b0) begin fails++; $display("FAIL ones_empty: got %b expected 0", bus.out0_val); end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b0, 4'h3, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 4'h4, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, 4'h9, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, 4'hC, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    #1;
    tests++; if (bus.out0_msg !== 4'h3 || bus.out1_msg !== 4'h9) begin fails++; $display("FAIL arst_prefill: got %h/%h expected 3/9", bus.out0_msg, bus.out1_msg); end
    rst = 1'b1;
    #1;
    tests++; if (bus.out0_val !== 1'b0 || bus.out1_val !== 1'b0) begin fails++; $display("FAIL arst_val: got %b/%b expected 0/0", bus.out0_val, bus.out1_val); end
    tests++; if (bus.out0_msg !== 4'h0 || bus.out1_msg !== 4'h0) begin fails++; $display("FAIL arst_msg: got %h/%h expected 0/0", bus.out0_msg, bus.out1_msg); end
`ifdef DEMUX2_ROUTER_COUNT_EN
    tests++; if (c0 !== 8'd0 || c1 !== 8'd0) begin fails++; $display("FAIL arst_counts: got %0d/%0d expected 0/0", c0, c1); end
`endif
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    tick();
    tests++; if (bus.out0_val !== 1'b0 || bus.out1_val !== 1'b0 || bus.out0_msg !== 4'h0 || bus.out1_msg !== 4'h0) begin
      fails++; $display("FAIL arst_stale: got val=%b/%b msg=%h/%h expected all 0", bus.out0_val, bus.out1_val, bus.out0_msg, bus.out1_msg);
    end
    bus.in_sel = 1'b1;
    #1;
    tests++; if (bus.in_rdy !== 1'b1) begin fails++; $display("FAIL arst_in_rdy: got %b expected 1", bus.in_rdy); end
  endtask

  task automatic test_random();
    logic [3:0] m0[$];
    logic [3:0] m1[$];
    int         n0 = 0;
    int         n1 = 0;
    logic       v, s, r0, r1, erdy, ix, o0x, o1x;
    logic [3:0] m;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      v  = 1'($urandom_range(0, 3) != 0);
      s  = 1'($urandom_range(0, 1));
      m  = 4'($urandom);
      r0 = 1'($urandom_range(0, 2) != 0);
      r1 = 1'($urandom_range(0, 3) == 0);
      drive(v, s, m, r0, r1);
      #1;
      erdy = s ? (m1.size() < 2) : (m0.size() < 2);
      tests++; if (bus.in_rdy !== erdy) begin fails++; $display("FAIL rnd_in_rdy c%0d: got %b expected %b", cyc, bus.in_rdy, erdy); end
      tests++; if (bus.out0_val !== (m0.size() > 0)) begin fails++; $display("FAIL rnd_out0_val c%0d: got %b expected %b", cyc, bus.out0_val, m0.size() > 0); end
      tests++; if (bus.out1_val !== (m1.size() > 0)) begin fails++; $display("FAIL rnd_out1_val c%0d: got %b expected %b", cyc, bus.out1_val, m1.size() > 0); end
      tests++; if (bus.out0_msg !== (m0.size() > 0 ? m0[0] : 4'h0)) begin fails++; $display("FAIL rnd_out0_msg c%0d: got %h expected %h", cyc, bus.out0_msg, m0.size() > 0 ? m0[0] : 4'h0); end
      tests++; if (bus.out1_msg !== (m1.size() > 0 ? m1[0] : 4'h0)) begin fails++; $display("FAIL rnd_out1_msg c%0d: got %h expected %h", cyc, bus.out1_msg, m1.size() > 0 ? m1[0] : 4'h0); end
`ifdef DEMUX2_ROUTER_COUNT_EN
      tests++; if (c0 !== 8'(n0) || c1 !== 8'(n1)) begin fails++; $display("FAIL rnd_counts c%0d: got %0d/%0d expected %0d/%0d", cyc, c0, c1, 8'(n0), 8'(n1)); end
`endif
      ix  = v && erdy;
      o0x = (m0.size() > 0) && r0;
      o1x = (m1.size() > 0) && r1;
      tick();
      if (o0x) begin void'(m0.pop_front()); n0++; end
      if (o1x) begin void'(m1.pop_front()); n1++; end
      if (ix) begin
        if (s) m1.push_back(m);
        else   m0.push_back(m);
      end
    end
    drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    tick();
    tick();
  endtask

`ifdef DEMUX2_ROUTER_COUNT_EN
  task automatic test_count();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    drive(1'b1, 1'b1, 4'h6, 1'b1, 1'b1);
    repeat (257) tick();
    drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    tick();
    tests++; if (c1 !== 8'd1) begin fails++; $display("FAIL count_out1_wrap: got %0d expected 1", c1); end
    tests++; if (c0 !== 8'd0) begin fails++; $display("FAIL count_out0: got %0d expected 0", c0); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_hol();
    test_ones_steady();
    test_async_reset();
    test_random();
`ifdef DEMUX2_ROUTER_COUNT_EN
    test_count();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
